fifo_push_arbiter: RTL and testbench

- Round-robin controller that shares the router's single FIFO write port among the five RX-side transceiver outputs (North, South, East, West, Local).
- It accepts one flit at a time over a 4-phase req/ack handshake, pushes the flit into the FIFO, and acknowledges the winning port.
- It sits between the RX transceiver array and the router FIFO.
- It guarantees that no flit is written to a full FIFO and that no requesting port starves.

---
 rtl/fifo_push_arbiter_pkg.sv | 14 +
 rtl/fifo_push_arbiter_if.sv | 28 ++
 rtl/fifo_push_arbiter_rr_pick.sv | 26 ++
 rtl/fifo_push_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_push_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_push_arbiter_pkg.sv
// Shared constants and FSM state type for the router FIFO push arbiter.
package fifo_push_arbiter_pkg;

  localparam int unsigned SIZE      = 8;
  localparam int unsigned BITS_DIR  = 3;
  localparam int unsigned NUM_PORTS = 5;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_ACK   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// RX-side push handshake plus FIFO write port; master is the arbiter, slave the surroundings.
interface fifo_push_arbiter_if
  import fifo_push_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = SIZE,
  parameter int unsigned PORTS  = NUM_PORTS
);

  logic [PORTS-1:0]        fifo_push_req;
  logic [PORTS-1:0]        fifo_push_ack;
  logic [PORTS*DATA_W-1:0] fifo_push_data;
  logic                    fifo_write;
  logic [DATA_W-1:0]       fifo_data_in;
  logic                    fifo_full;
  logic [BITS_DIR-1:0]     grant;
  logic                    busy;

  modport master (
    input  fifo_push_req, fifo_push_data, fifo_full,
    output fifo_push_ack, fifo_write, fifo_data_in, grant, busy
  );

  modport slave (
    output fifo_push_req, fifo_push_data, fifo_full,
    input  fifo_push_ack, fifo_write, fifo_data_in, grant, busy
  );

endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after i_last, wrapping modulo PORTS.
module fifo_push_arbiter_rr_pick
  import fifo_push_arbiter_pkg::*;
#(
  parameter int unsigned PORTS = NUM_PORTS
) (
  input  logic [PORTS-1:0]    i_req,
  input  logic [BITS_DIR-1:0] i_last,
  output logic                o_any,
  output logic [BITS_DIR-1:0] o_idx
);

  always_comb begin
    o_any = 1'b0;
    o_idx = i_last;
    for (int unsigned k = 1; k <= PORTS; k++) begin
      int unsigned pos;
      pos = (32'(i_last) + k) % PORTS;
      if (!o_any && i_req[pos]) begin
        o_any = 1'b1;
        o_idx = BITS_DIR'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares the single router FIFO write port among the RX transceivers via 4-phase req/ack.
module fifo_push_arbiter
  import fifo_push_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = SIZE,
  parameter int unsigned PORTS  = NUM_PORTS
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_push_arbiter_if.master  bus
);

  arb_state_e          r_state, w_state_nxt;
  logic [PORTS-1:0]    r_ack, w_ack_nxt;
  logic                r_write, w_write_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt, w_sel_data;
  logic [BITS_DIR-1:0] r_grant, w_grant_nxt;
  logic [BITS_DIR-1:0] r_last, w_last_nxt;
  logic [BITS_DIR-1:0] w_idx;
  logic [PORTS-1:0]    w_req_open;
  logic                w_any, w_granted_req;

  assign w_req_open = bus.fifo_push_req & ~r_ack;

  fifo_push_arbiter_rr_pick #(.PORTS(PORTS)) u_pick (
    .i_req  (w_req_open),
    .i_last (r_last),
    .o_any  (w_any),
    .o_idx  (w_idx)
  );

  always_comb begin
    w_sel_data    = '0;
    w_granted_req = 1'b0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (w_idx == BITS_DIR'(p))
        w_sel_data = bus.fifo_push_data[p*DATA_W +: DATA_W];
      if (r_grant == BITS_DIR'(p))
        w_granted_req = bus.fifo_push_req[p];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_write_nxt = r_write;
    w_data_nxt  = r_data;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      ARB_IDLE: begin
        if (w_any && !bus.fifo_full) begin
          w_grant_nxt = w_idx;
          w_data_nxt  = w_sel_data;
          w_write_nxt = 1'b1;
          w_state_nxt = ARB_WRITE;
        end
      end
      // Full is not re-checked here: this block is the FIFO's only writer.
      ARB_WRITE: begin
        w_write_nxt = 1'b0;
        for (int unsigned p = 0; p < PORTS; p++)
          w_ack_nxt[p] = (r_grant == BITS_DIR'(p));
        w_state_nxt = ARB_ACK;
      end
      ARB_ACK: begin
        if (!w_granted_req) begin
          w_ack_nxt   = '0;
          w_last_nxt  = r_grant;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack   <= '0;
      r_write <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
      r_last  <= BITS_DIR'(PORTS - 1);
    end else begin
      r_ack   <= w_ack_nxt;
      r_write <= w_write_nxt;
      r_data  <= w_data_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign bus.fifo_push_ack = r_ack;
  assign bus.fifo_write    = r_write;
  assign bus.fifo_data_in  = r_data;
  assign bus.grant         = r_grant;
  assign bus.busy          = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: transceiver models, per-flit scoreboard, reference arbiter.
module tb_fifo_push_arbiter;
  import fifo_push_arbiter_pkg::*;

  localparam int unsigned DW = SIZE;
  localparam int          NP = NUM_PORTS;

  typedef struct packed {
    logic [2:0]    port;
    logic [DW-1:0] data;
  } flit_t;

  logic clk = 1'b0;
  logic reset;

  fifo_push_arbiter_if #(.DATA_W(DW), .PORTS(NP)) bus ();

  fifo_push_arbiter #(.DATA_W(DW), .PORTS(NP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transceiver side
  logic [NP-1:0] req;
  logic [DW-1:0] dat [NP];
  logic [DW-1:0] nxt [NP];
  int            pend [NP];
  bit            hold [NP];
  bit            viol [NP];
  bit            rnd_mode;

  // Inputs as seen by the DUT at the coming edge
  logic [NP-1:0] req_d;
  logic          full_d;

  // Reference arbiter
  int            m_st;
  logic [NP-1:0] m_ack;
  logic          m_write;
  logic [2:0]    m_grant, m_last;
  int            waits [NP];

  flit_t      sb [$];
  logic [2:0] order [$];
  int         n_push;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] rr_ref(input logic [NP-1:0] r, input logic [2:0] last);
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (int'(last) + k) % NP;
      if (r[p]) return 3'(p);
    end
    return last;
  endfunction

  task automatic drive_bus();
    bus.fifo_push_req = req;
    for (int p = 0; p < NP; p++) bus.fifo_push_data[p*DW +: DW] = dat[p];
    req_d  = req;
    full_d = bus.fifo_full;
  endtask

  task automatic step();
    logic [2:0] g;
    int idx;
    @(posedge clk);
    #1;
    case (m_st)
      0: if ((req_d & ~m_ack) != '0 && !full_d) begin
        g = rr_ref(req_d & ~m_ack, m_last);
        for (int p = 0; p < NP; p++) if (p != int'(g) && req_d[p]) waits[p]++;
        chk("starve", (waits[g] <= NP - 1) ? 1 : 0, 1);
        waits[g] = 0;
        m_grant = g; m_write = 1'b1; m_st = 1;
      end
      1: begin
        m_write = 1'b0; m_ack = '0; m_ack[m_grant] = 1'b1; m_st = 2;
      end
      default: if (!req_d[m_grant]) begin
        m_ack = '0; m_last = m_grant; m_st = 0;
      end
    endcase
    chk("write", bus.fifo_write, m_write);
    chk("ack", bus.fifo_push_ack, m_ack);
    chk("grant", bus.grant, m_grant);
    chk("busy", bus.busy, m_st != 0);
    chk("ack_onehot0", $onehot0(bus.fifo_push_ack), 1);
    if (bus.fifo_write) begin
      n_push++;
      order.push_back(bus.grant);
      chk("no_write_when_full", full_d, 0);
      idx = -1;
      foreach (sb[i]) if (idx < 0 && sb[i].port == bus.grant) idx = i;
      chk("sb_hit", (idx >= 0) ? 1 : 0, 1);
      if (idx >= 0) begin
        chk("data", bus.fifo_data_in, sb[idx].data);
        sb.delete(idx);
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (req[p]) begin
        if (viol[p] && bus.fifo_write && int'(bus.grant) == p) begin
          req[p] = 1'b0; viol[p] = 1'b0;
        end else if (bus.fifo_push_ack[p] && !hold[p]) begin
          req[p] = 1'b0;
        end
      end else if (!bus.fifo_push_ack[p]) begin
        if (pend[p] > 0) begin
          pend[p]--; dat[p] = nxt[p]; nxt[p] = nxt[p] + 1'b1;
          req[p] = 1'b1; sb.push_back({3'(p), dat[p]});
        end else if (rnd_mode && $urandom_range(0, 3) == 0) begin
          dat[p] = DW'($urandom); req[p] = 1'b1; sb.push_back({3'(p), dat[p]});
        end
      end
    end
    if (rnd_mode) bus.fifo_full = ($urandom_range(0, 2) == 0);
    drive_bus();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    m_st = 0; m_ack = '0; m_write = 1'b0; m_grant = '0; m_last = 3'(NP - 1);
    for (int p = 0; p < NP; p++) waits[p] = 0;
    chk("rst_write", bus.fifo_write, 0);
    chk("rst_ack", bus.fifo_push_ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_data", bus.fifo_data_in, 0);
    chk("rst_grant", bus.grant, 0);
    // Ports still holding req re-present their flit after reset
    sb.delete();
    for (int p = 0; p < NP; p++) if (req[p]) sb.push_back({3'(p), dat[p]});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    step();
    while ((req != '0 || bus.busy) && k < 300) begin
      step();
      k++;
    end
    chk("drain_bound", (k < 300) ? 1 : 0, 1);
  endtask

  initial begin
    reset = 1'b0;
    req = '0; rnd_mode = 1'b0; n_push = 0;
    bus.fifo_full = 1'b0;
    for (int p = 0; p < NP; p++) begin
      dat[p] = '0; nxt[p] = '0; pend[p] = 0; hold[p] = 1'b0; viol[p] = 1'b0;
    end
    drive_bus();
    do_reset();

    // Single request on port 2
    nxt[2] = 8'h5A; pend[2] = 1; n_push = 0;
    repeat (8) step();
    chk("t1_pushes", n_push, 1);
    chk("t1_ack_low", bus.fifo_push_ack, 0);

    // All five ports, two flits each: 0,1,2,3,4,0,1,2,3,4
    do_reset();
    order.delete();
    for (int p = 0; p < NP; p++) begin nxt[p] = 8'h10 + 8'(p); pend[p] = 2; end
    drain();
    chk("t2_count", order.size(), 10);
    for (int i = 0; i < 10 && i < order.size(); i++) chk("t2_order", order[i], i % NP);

    // Rotation: after port 3 is served, 4 beats 1
    do_reset();
    pend[3] = 1;
    drain();
    order.delete();
    pend[1] = 1; pend[4] = 1;
    drain();
    chk("t3_count", order.size(), 2);
    if (order.size() == 2) begin
      chk("t3_first", order[0], 4);
      chk("t3_second", order[1], 1);
    end

    // FIFO full holds off the grant
    do_reset();
    bus.fifo_full = 1'b1; full_d = 1'b1;
    pend[0] = 1; n_push = 0;
    repeat (10) step();
    chk("t4_no_write", n_push, 0);
    chk("t4_req_held", req[0], 1);
    bus.fifo_full = 1'b0; full_d = 1'b0;
    step();
    chk("t4_write_after_full", bus.fifo_write, 1);
    drain();

    // Reset while ack[3] is high; port 3 re-presents and beats port 4
    do_reset();
    hold[3] = 1'b1; pend[3] = 1;
    for (int k = 0; k < 20 && !bus.fifo_push_ack[3]; k++) step();
    chk("t5_ack_seen", bus.fifo_push_ack[3], 1);
    do_reset();
    hold[3] = 1'b0;
    order.delete();
    pend[4] = 1;
    drain();
    chk("t5_count", order.size(), 2);
    if (order.size() == 2) begin
      chk("t5_first", order[0], 3);
      chk("t5_second", order[1], 4);
    end

    // Req dropped during WRITE: still one push
    do_reset();
    viol[1] = 1'b1; pend[1] = 1; n_push = 0;
    drain();
    chk("t6_pushes", n_push, 1);

    // Random traffic with random full
    do_reset();
    rnd_mode = 1'b1;
    repeat (10000) step();
    rnd_mode = 1'b0;
    bus.fifo_full = 1'b0; full_d = 1'b0;
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
